systolic_matmul_engine: RTL

Parametrised N×N output-stationary systolic matrix-multiply engine: computes C = A·B, or C = C + A·B in accumulate mode, for N×N operand matrices of W_DATA-bit elements. It contains the operand skew buffers, the control FSM and the PE grid. It adds a valid/ready handshake on input and result, result back-pressure, signed operation and tiled accumulation. It sits between the operand-fetch logic and the result-writeback logic.

---
 rtl/systolic_matmul_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: N x N output-stationary systolic matrix multiplier.
// Rows of A enter skewed from the left and columns of B skewed from the top.
// Each PE owns one element of C. Valid/ready handshakes sit on both the
// operand and result sides, and the engine supports signed operands and
// tiled accumulation (C = C + A*B).
module systolic_matmul_engine #(
   parameter int N      = 4,
   parameter int W_DATA = 8,
   parameter int SIGNED = 0,
   localparam int W_ACC = 2*W_DATA + $clog2(N)
) (
   input  logic                            i_clk,
   input  logic                            i_arst_n,
   input  logic [N-1:0][N-1:0][W_DATA-1:0] i_a,
   input  logic [N-1:0][N-1:0][W_DATA-1:0] i_b,
   input  logic                            i_accumulate,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic [N-1:0][N-1:0][W_ACC-1:0]  o_c,
   output logic                            o_valid,
   input  logic                            i_ready
);
   localparam int L     = 2*N - 1;           // skew register depth: N data plus up to N-1 lead zeros
   localparam int W_CNT = $clog2(3*N - 1);
   localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(3*N - 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W_CNT-1:0]  cnt_q, cnt_d;
   logic              accept_s;
   logic              compute_s;

   // a_sr_q[i] holds row i of A, b_sr_q[j] holds column j of B; element 0 is the head
   logic [N-1:0][L-1:0][W_DATA-1:0]   a_sr_q, a_sr_d;
   logic [N-1:0][L-1:0][W_DATA-1:0]   b_sr_q, b_sr_d;
   // Forwarding registers; the last column/row has no consumer so it is not kept
   logic [N-1:0][N-2:0][W_DATA-1:0]   a_pe_q, a_pe_d;
   logic [N-2:0][N-1:0][W_DATA-1:0]   b_pe_q, b_pe_d;
   logic [N-1:0][N-1:0][W_ACC-1:0]    acc_q, acc_d;
   // Operand seen by PE(i,j) this cycle
   logic [N-1:0][N-1:0][W_DATA-1:0]   a_w_s;
   logic [N-1:0][N-1:0][W_DATA-1:0]   b_w_s;

   // Widen an operand to the accumulator width (sign- or zero-extension)
   function automatic logic [W_ACC-1:0] ext(input logic [W_DATA-1:0] v);
      if (SIGNED != 0) begin
         return {{(W_ACC-W_DATA){v[W_DATA-1]}}, v};
      end else begin
         return {{(W_ACC-W_DATA){1'b0}}, v};
      end
   endfunction

   assign accept_s  = i_valid & o_ready;
   assign compute_s = (state_q == ST_COMPUTE);
   assign o_c       = acc_q;

   // Control FSM: next state, step counter and handshake outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_d = ST_COMPUTE;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COMPUTE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               cnt_d   = {W_CNT{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            o_valid = 1'b1;
            o_ready = i_ready;
            if (i_ready && i_valid) begin
               state_d = ST_COMPUTE;
               cnt_d   = CNT_ONE;
            end else if (i_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {W_CNT{1'b0}};
         end
      endcase
   end

   // Grid wiring: column 0 / row 0 take the skew heads, the rest take the neighbour registers
   always_comb begin
      a_w_s = '0;
      b_w_s = '0;
      for (int i = 0; i < N; i++) begin
         a_w_s[i][0] = a_sr_q[i][0];
         b_w_s[0][i] = b_sr_q[i][0];
         for (int j = 1; j < N; j++) begin
            a_w_s[i][j] = a_pe_q[i][j-1];
            b_w_s[j][i] = b_pe_q[j-1][i];
         end
      end
   end

   // Datapath next state: load skew on accept, shift and multiply-accumulate while computing
   always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      a_pe_d = a_pe_q;
      b_pe_d = b_pe_q;
      acc_d  = acc_q;
      if (accept_s) begin
         a_sr_d = '0;
         b_sr_d = '0;
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               a_sr_d[i][i+k] = i_a[i][k];
               b_sr_d[i][i+k] = i_b[k][i];
            end
         end
         a_pe_d = '0;
         b_pe_d = '0;
         if (!i_accumulate) begin
            acc_d = '0;
         end else begin
            acc_d = acc_q;
         end
      end else if (compute_s) begin
         for (int i = 0; i < N; i++) begin
            for (int p = 0; p < L-1; p++) begin
               a_sr_d[i][p] = a_sr_q[i][p+1];
               b_sr_d[i][p] = b_sr_q[i][p+1];
            end
            a_sr_d[i][L-1] = '0;
            b_sr_d[i][L-1] = '0;
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N-1; j++) begin
               a_pe_d[i][j] = a_w_s[i][j];
               b_pe_d[j][i] = b_w_s[j][i];
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_d[i][j] = acc_q[i][j] + ext(a_w_s[i][j]) * ext(b_w_s[i][j]);
            end
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // State, counter, skew buffers, PE registers and accumulators
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= {W_CNT{1'b0}};
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         a_pe_q  <= '0;
         b_pe_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         a_pe_q  <= a_pe_d;
         b_pe_q  <= b_pe_d;
         acc_q   <= acc_d;
      end
   end

endmodule
